// File: rtl/ram_burst_reader.sv
// ram_burst_reader
//   Read-side burst engine for the 32x4 dual-port RAM. It walks a burst of
//   len_m1+1 addresses starting at base_addr (wrapping modulo 2^AW), issues
//   RAM reads, captures each returned word into a 2-entry buffer and presents
//   the words as a valid/ready stream. done pulses once the final word has
//   been accepted downstream.
//
// Ports
//   clk, rst_n          clock, async active-low reset
//   start               begin a burst (honoured only in IDLE)
//   base_addr, len_m1   burst base address and length-1, latched on start
//   busy, done          burst in progress / one-cycle completion pulse
//   ram_en, ram_addr    RAM read port (RAM registers the address on ram_en)
//   ram_dout            RAM read data, valid the cycle after the ram_en edge
//   m_valid, m_data,
//   m_last, m_ready     output stream; m_last tags the final burst word
module ram_burst_reader #(
    parameter int AW = 5,
    parameter int DW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [AW-1:0] len_m1,
    output logic          busy,
    output logic          done,
    output logic          ram_en,
    output logic [AW-1:0] ram_addr,
    input  logic [DW-1:0] ram_dout,
    output logic          m_valid,
    output logic [DW-1:0] m_data,
    output logic          m_last,
    input  logic          m_ready
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]          state;
    logic [AW-1:0]       ptr;
    logic [AW:0]         issue_cnt;
    logic                inflight;
    logic                inflight_last;
    logic [1:0][DW-1:0]  buf_d;
    logic [1:0]          buf_l;
    logic                rd_ptr;
    logic                wr_ptr;
    logic [1:0]          occ;

    logic                issue;
    logic                pop;
    logic                push;
    logic                final_issue;
    logic [2:0]          level;

    assign pop         = m_valid && m_ready;
    assign push        = inflight;
    assign final_issue = (issue_cnt == (AW+1)'(1));

    // Words that will be held once this cycle settles: buffered + returning
    // read - word leaving. Issuing only below 2 keeps the buffer from ever
    // overflowing, since every issued read lands in it one cycle later.
    assign level = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    assign issue = (state == S_RUN) && (issue_cnt != '0) && (level < 3'd2);

    assign ram_en   = issue;
    assign ram_addr = ptr;
    assign m_valid  = (occ != 2'd0);
    assign m_data   = buf_d[rd_ptr];
    assign m_last   = buf_l[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            ptr       <= '0;
            issue_cnt <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        ptr       <= base_addr;
                        issue_cnt <= {1'b0, len_m1} + (AW+1)'(1);
                        busy      <= 1'b1;
                        state     <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (issue) begin
                        ptr       <= ptr + AW'(1);
                        issue_cnt <= issue_cnt - (AW+1)'(1);
                        if (final_issue) state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // Acceptance of the tagged word means nothing is left in
                    // flight or buffered.
                    if (pop && m_last) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            buf_d         <= '0;
            buf_l         <= '0;
            rd_ptr        <= 1'b0;
            wr_ptr        <= 1'b0;
            occ           <= 2'd0;
        end else begin
            inflight      <= issue;
            inflight_last <= issue && final_issue;
            if (push) begin
                buf_d[wr_ptr] <= ram_dout;
                buf_l[wr_ptr] <= inflight_last;
                wr_ptr        <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            occ <= occ + {1'b0, push} - {1'b0, pop};
        end
    end

`ifndef SYNTHESIS
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && occ == 2'd2));
`endif

endmodule

// File: tb/tb_ram_burst_reader.sv
module tb_ram_burst_reader;
    localparam int AW = 5;
    localparam int DW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW-1:0] len_m1 = '0;
    logic          busy, done, ram_en, m_valid, m_last;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_dout = '0;
    logic [DW-1:0] m_data;
    logic          m_ready = 1'b0;
    logic [DW-1:0] mem [32];

    int checks = 0;
    int errors = 0;

    logic [3:0] got_d[$];
    logic       got_l[$];
    logic [4:0] got_a[$];
    int first_en, first_valid, last_pop, done_cyc, busy_c1, timeout, viol, stall_err;

    ram_burst_reader #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .len_m1(len_m1), .busy(busy), .done(done), .ram_en(ram_en),
        .ram_addr(ram_addr), .ram_dout(ram_dout), .m_valid(m_valid),
        .m_data(m_data), .m_last(m_last), .m_ready(m_ready)
    );

    always #5 clk = ~clk;

    // RAM read port: address registered on ram_en, data next cycle.
    always @(posedge clk) if (ram_en) ram_dout <= mem[ram_addr];

    function automatic logic rdy(input int mode, input int c);
        if (mode == 0) return 1'b1;
        case (c % 6)
            0: return 1'b1;
            1: return 1'b0;
            2: return 1'b0;
            3: return 1'b1;
            4: return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    // Launch a burst and record what the DUT does until done (or budget).
    task automatic run_burst(input logic [4:0] b, input logic [4:0] l,
                             input int mode, input int glitch, input int budget);
        int outst;
        logic pv, pr, pl, pop;
        logic [3:0] pd;
        got_d.delete(); got_l.delete(); got_a.delete();
        first_en = -1; first_valid = -1; last_pop = -1; done_cyc = -1;
        busy_c1 = 0; timeout = 1; viol = 0; stall_err = 0;
        outst = 0; pv = 0; pr = 0; pl = 0; pd = 0;
        @(negedge clk);
        start = 1'b1; base_addr = b; len_m1 = l; m_ready = rdy(mode, 0);
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            if (c == glitch) begin
                start = 1'b1; base_addr = b + 5'd7; len_m1 = l + 5'd9;
            end else start = 1'b0;
            m_ready = rdy(mode, c);
            #1;
            if (c == 1) busy_c1 = int'(busy);
            if (pv && !pr && !(m_valid === 1'b1 && m_data === pd && m_last === pl)) stall_err++;
            pop = m_valid && m_ready;
            if (ram_en === 1'b1) begin
                got_a.push_back(ram_addr);
                if (first_en < 0) first_en = c;
                if (outst - int'(pop) >= 2) viol++;
            end
            if (m_valid === 1'b1 && first_valid < 0) first_valid = c;
            if (done === 1'b1) begin
                done_cyc = c; timeout = 0;
                break;
            end
            if (pop) begin
                got_d.push_back(m_data); got_l.push_back(m_last); last_pop = c;
            end
            outst += int'(ram_en) - int'(pop);
            pv = m_valid; pr = m_ready; pd = m_data; pl = m_last;
        end
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({busy, done, ram_en, ram_addr, m_valid, m_data, m_last} !== 14'd0) begin
            errors++;
            $display("FAIL reset_outputs got %b want all zero",
                     {busy, done, ram_en, ram_addr, m_valid, m_data, m_last});
        end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_basic();
        run_burst(5'd3, 5'd4, 0, 0, 50);
        checks++; if (timeout !== 0) begin errors++; $display("FAIL basic_timeout got %0d want 0", timeout); end
        checks++; if (first_en !== 1) begin errors++; $display("FAIL basic_first_en got %0d want 1", first_en); end
        checks++; if (first_valid !== 3) begin errors++; $display("FAIL basic_first_valid got %0d want 3", first_valid); end
        checks++; if (busy_c1 !== 1) begin errors++; $display("FAIL basic_busy got %0d want 1", busy_c1); end
        checks++; if (got_d.size() !== 5) begin errors++; $display("FAIL basic_count got %0d want 5", got_d.size()); end
        for (int i = 0; i < 5 && i < got_d.size(); i++) begin
            checks++;
            if (got_d[i] !== 4'(3 + i) || got_l[i] !== (i == 4)) begin
                errors++;
                $display("FAIL basic_word%0d got d=%0d l=%0d want d=%0d l=%0d", i, got_d[i], got_l[i], 3 + i, i == 4);
            end
        end
        checks++; if (last_pop !== 7) begin errors++; $display("FAIL basic_last_pop got %0d want 7", last_pop); end
        checks++; if (done_cyc !== 8) begin errors++; $display("FAIL basic_done_cyc got %0d want 8", done_cyc); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done got %b want 0", busy); end
        @(negedge clk); #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got %b want 0", done); end
    endtask

    task automatic test_wrap();
        logic [4:0] ea[4];
        logic [3:0] ed[4];
        ea = '{5'd30, 5'd31, 5'd0, 5'd1};
        ed = '{4'd14, 4'd15, 4'd0, 4'd1};
        run_burst(5'd30, 5'd3, 0, 0, 50);
        checks++; if (timeout !== 0 || got_a.size() !== 4 || got_d.size() !== 4) begin
            errors++; $display("FAIL wrap_count got a=%0d d=%0d to=%0d want 4 4 0", got_a.size(), got_d.size(), timeout);
        end
        for (int i = 0; i < 4 && i < got_a.size() && i < got_d.size(); i++) begin
            checks++;
            if (got_a[i] !== ea[i] || got_d[i] !== ed[i]) begin
                errors++; $display("FAIL wrap_word%0d got a=%0d d=%0d want a=%0d d=%0d", i, got_a[i], got_d[i], ea[i], ed[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        run_burst(5'd0, 5'd7, 1, 0, 200);
        checks++; if (timeout !== 0 || got_d.size() !== 8) begin
            errors++; $display("FAIL bp_count got %0d to=%0d want 8 0", got_d.size(), timeout);
        end
        for (int i = 0; i < 8 && i < got_d.size(); i++) begin
            checks++;
            if (got_d[i] !== 4'(i) || got_l[i] !== (i == 7)) begin
                errors++; $display("FAIL bp_word%0d got d=%0d l=%0d want d=%0d l=%0d", i, got_d[i], got_l[i], i, i == 7);
            end
        end
        checks++; if (viol !== 0) begin errors++; $display("FAIL bp_issue_rule got %0d want 0", viol); end
        checks++; if (stall_err !== 0) begin errors++; $display("FAIL bp_stall_stable got %0d want 0", stall_err); end
    endtask

    task automatic test_single();
        run_burst(5'd9, 5'd0, 0, 0, 50);
        checks++; if (timeout !== 0 || got_d.size() !== 1 || got_a.size() !== 1) begin
            errors++; $display("FAIL single_count got d=%0d a=%0d to=%0d want 1 1 0", got_d.size(), got_a.size(), timeout);
        end else begin
            checks++;
            if (got_d[0] !== 4'd9 || got_l[0] !== 1'b1) begin
                errors++; $display("FAIL single_word got d=%0d l=%0d want d=9 l=1", got_d[0], got_l[0]);
            end
        end
    endtask

    task automatic test_full();
        int bad;
        run_burst(5'd5, 5'd31, 0, 0, 100);
        checks++; if (timeout !== 0 || got_d.size() !== 32 || got_a.size() !== 32) begin
            errors++; $display("FAIL full_count got d=%0d a=%0d to=%0d want 32 32 0", got_d.size(), got_a.size(), timeout);
        end else begin
            bad = 0;
            for (int i = 0; i < 32; i++)
                if (got_d[i] !== 4'((5 + i) % 16) || got_l[i] !== (i == 31)) bad++;
            checks++; if (bad !== 0) begin errors++; $display("FAIL full_words got %0d bad want 0", bad); end
            checks++; if (got_a[31] !== 5'd4) begin errors++; $display("FAIL full_last_addr got %0d want 4", got_a[31]); end
        end
    endtask

    task automatic test_back_to_back();
        run_burst(5'd10, 5'd2, 0, 2, 50);
        checks++; if (timeout !== 0 || got_d.size() !== 3) begin
            errors++; $display("FAIL ignore_count got %0d to=%0d want 3 0", got_d.size(), timeout);
        end
        for (int i = 0; i < 3 && i < got_d.size(); i++) begin
            checks++;
            if (got_d[i] !== 4'(10 + i)) begin errors++; $display("FAIL ignore_word%0d got %0d want %0d", i, got_d[i], 10 + i); end
        end
        run_burst(5'd1, 5'd1, 0, 0, 50);
        checks++; if (first_en !== 1) begin errors++; $display("FAIL b2b_first_en got %0d want 1", first_en); end
        checks++; if (timeout !== 0 || got_d.size() !== 2) begin
            errors++; $display("FAIL b2b_count got %0d to=%0d want 2 0", got_d.size(), timeout);
        end else begin
            checks++;
            if (got_d[0] !== 4'd1 || got_d[1] !== 4'd2 || got_l[1] !== 1'b1) begin
                errors++; $display("FAIL b2b_words got %0d %0d l=%0d want 1 2 l=1", got_d[0], got_d[1], got_l[1]);
            end
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk); start = 1'b1; base_addr = 5'd0; len_m1 = 5'd7; m_ready = 1'b0;
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (m_valid !== 1'b1 || ram_en !== 1'b0 || m_data !== 4'd0) begin
            errors++; $display("FAIL rmid_full got v=%b en=%b d=%0d want v=1 en=0 d=0", m_valid, ram_en, m_data);
        end
        rst_n = 1'b0; #1;
        checks++;
        if (m_valid !== 1'b0 || busy !== 1'b0 || ram_en !== 1'b0) begin
            errors++; $display("FAIL rmid_reset got v=%b busy=%b en=%b want 0 0 0", m_valid, busy, ram_en);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (done !== 1'b0) begin errors++; $display("FAIL rmid_no_done got %b want 0", done); end
        end
        rst_n = 1'b1;
        @(negedge clk); #1;
        checks++; if (done !== 1'b0 || m_valid !== 1'b0) begin
            errors++; $display("FAIL rmid_after got done=%b v=%b want 0 0", done, m_valid);
        end
        run_burst(5'd8, 5'd2, 0, 0, 50);
        checks++; if (timeout !== 0 || got_d.size() !== 3) begin
            errors++; $display("FAIL rmid_fresh_count got %0d to=%0d want 3 0", got_d.size(), timeout);
        end else begin
            checks++;
            if (got_d[0] !== 4'd8 || got_d[1] !== 4'd9 || got_d[2] !== 4'd10 || got_l[2] !== 1'b1 || got_l[0] !== 1'b0) begin
                errors++; $display("FAIL rmid_fresh_words got %0d %0d %0d want 8 9 10", got_d[0], got_d[1], got_d[2]);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = i[3:0];
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_single();
        test_full();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
